// File: rtl/async_fifo_lvl.sv
// Dual-clock Gray-pointer FIFO with registered read data, fill levels
// and almost flags; define ASYNC_FIFO_ERR_FLAGS_EN for sticky error flags.
`timescale 1ns/1ps
module async_fifo_lvl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 12,
  parameter int AE_THRESH   = 2
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   rlevel
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  woverflow,
  output logic                  runderflow
`endif
);

  localparam int AW    = ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] AF_LVL = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_LVL = (AW+1)'(AE_THRESH);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // write-domain state
  logic [AW:0] wbin_q, wbin_d;
  logic [AW:0] wgray_q, wgray_d;
  logic        wfull_q, wfull_d;
  logic        waf_q, waf_d;
  logic [AW:0] wlevel_q, wlevel_d;
  logic [AW:0] r2w_q [SYNC_STAGES];
  logic [AW:0] rgray_s, rbin_s;
  logic        wen;

  // read-domain state
  logic [AW:0]           rbin_q, rbin_d;
  logic [AW:0]           rgray_q, rgray_d;
  logic                  rempty_q, rempty_d;
  logic                  rae_q, rae_d;
  logic [AW:0]           rlevel_q, rlevel_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [AW:0]           w2r_q [SYNC_STAGES];
  logic [AW:0]           wgray_s, wbin_s;
  logic                  ren;

  // write side: next pointers, full flag and writer's view of occupancy
  always_comb begin
    wen      = winc & ~wfull_q;
    wbin_d   = wbin_q + (AW+1)'(wen);
    wgray_d  = bin2gray(wbin_d);
    rgray_s  = r2w_q[SYNC_STAGES-1];
    rbin_s   = gray2bin(rgray_s);
    wfull_d  = (wgray_d ==
                {~rgray_s[AW:AW-1], rgray_s[AW-2:0]});
    wlevel_d = wbin_d - rbin_s;
    waf_d    = (wlevel_d >= AF_LVL);
  end

  // write side registers
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wfull_q  <= 1'b0;
      waf_q    <= (AF_THRESH == 0);
      wlevel_q <= '0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wfull_q  <= wfull_d;
      waf_q    <= waf_d;
      wlevel_q <= wlevel_d;
    end
  end

  // read Gray pointer into the write clock
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r2w_q[i] <= '0;
    end else begin
      r2w_q[0] <= rgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) r2w_q[i] <= r2w_q[i-1];
    end
  end

  // storage array, written only on accepted writes
  always_ff @(posedge wclk) begin
    if (wen) mem[wbin_q[AW-1:0]] <= wdata;
  end

  // read side: next pointers, empty flag, reader's occupancy, data pop
  always_comb begin
    ren      = rinc & ~rempty_q;
    rbin_d   = rbin_q + (AW+1)'(ren);
    rgray_d  = bin2gray(rbin_d);
    wgray_s  = w2r_q[SYNC_STAGES-1];
    wbin_s   = gray2bin(wgray_s);
    rempty_d = (rgray_d == wgray_s);
    rlevel_d = wbin_s - rbin_d;
    rae_d    = (rlevel_d <= AE_LVL);
    rvalid_d = ren;
    rdata_d  = ren ? mem[rbin_q[AW-1:0]] : rdata_q;
  end

  // read side registers
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      rempty_q <= 1'b1;
      rae_q    <= 1'b1;
      rlevel_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      rempty_q <= rempty_d;
      rae_q    <= rae_d;
      rlevel_q <= rlevel_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // write Gray pointer into the read clock
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) w2r_q[i] <= '0;
    end else begin
      w2r_q[0] <= wgray_q;
      for (int i = 1; i < SYNC_STAGES; i++) w2r_q[i] <= w2r_q[i-1];
    end
  end

  assign wfull         = wfull_q;
  assign walmost_full  = waf_q;
  assign wlevel        = wlevel_q;
  assign rdata         = rdata_q;
  assign rvalid        = rvalid_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = rae_q;
  assign rlevel        = rlevel_q;

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic wovf_q, wovf_d;
  logic rudf_q, rudf_d;

  // sticky flags for rejected accesses
  always_comb begin
    wovf_d = wovf_q | (winc & wfull_q);
    rudf_d = rudf_q | (rinc & rempty_q);
  end

  // overflow flag, cleared only by write reset
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) wovf_q <= 1'b0;
    else         wovf_q <= wovf_d;
  end

  // underflow flag, cleared only by read reset
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) rudf_q <= 1'b0;
    else         rudf_q <= rudf_d;
  end

  assign woverflow  = wovf_q;
  assign runderflow = rudf_q;
`endif

endmodule

// File: tb/tb_async_fifo_lvl.sv
// Randomised bench for async_fifo_lvl against a queue model
// of FIFO contents and true occupancy.
`timescale 1ns/1ps
module tb_async_fifo_lvl;

  logic       wclk = 1'b0;
  logic       rclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       rrst_n = 1'b0;
  logic       winc = 1'b0;
  logic       rinc = 1'b0;
  logic [7:0] wdata = '0;
  logic       wfull, walmost_full, rvalid, rempty, ralmost_empty;
  logic [7:0] rdata;
  logic [4:0] wlevel, rlevel;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic       woverflow, runderflow;
`endif

  int         checks = 0;
  int         failures = 0;
  logic [7:0] model_q [$];
  int         occ = 0;
  bit         mon_en = 1'b0;

  async_fifo_lvl dut (
    .wclk          (wclk),
    .wrst_n        (wrst_n),
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .winc          (winc),
    .wdata         (wdata),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .wlevel        (wlevel),
    .rinc          (rinc),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    .woverflow     (woverflow),
    .runderflow    (runderflow)
`endif
  );

  always #5    wclk = ~wclk;
  always #13.5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // called at wclk edge + 1; returns at the next wclk edge + 1
  task automatic wr_cycle(input logic en, input logic [7:0] d,
                          output logic acc);
    winc  = en;
    wdata = d;
    acc   = en & ~wfull;
    @(posedge wclk);
    #1;
    winc = 1'b0;
    if (acc) begin
      model_q.push_back(d);
      occ++;
    end
  endtask

  // called at rclk edge + 1; returns at the next rclk edge + 1
  task automatic rd_cycle(input logic en, output logic acc);
    logic [7:0] exp;
    rinc = en;
    acc  = en & ~rempty;
    @(posedge rclk);
    #1;
    rinc = 1'b0;
    if (acc) begin
      occ--;
      chk("rd_model_nonempty", 32'(model_q.size() > 0), 32'd1);
      if (model_q.size() > 0) begin
        exp = model_q.pop_front();
        chk("rdata", 32'(rdata), 32'(exp));
      end
      chk("rvalid", 32'(rvalid), 32'd1);
    end else begin
      chk("rvalid_idle", 32'(rvalid), 32'd0);
    end
  endtask

  // conservative levels: wlevel >= true occupancy >= rlevel
  always @(negedge rclk) begin
    #2.5;
    if (mon_en) begin
      chk("wlevel_ge_occ", 32'(int'(wlevel) >= occ), 32'd1);
      chk("occ_ge_rlevel", 32'(occ >= int'(rlevel)), 32'd1);
    end
  end

  initial begin
    #600000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   nw, nr, lat;

    // reset then idle
    repeat (5) @(posedge rclk);
    #1;
    chk("rst_rempty_in", 32'(rempty), 32'd1);
    chk("rst_wfull_in", 32'(wfull), 32'd0);
    #1;
    wrst_n = 1'b1;
    rrst_n = 1'b1;
    @(posedge wclk);
    #1;
    chk("rst_rempty", 32'(rempty), 32'd1);
    chk("rst_rae", 32'(ralmost_empty), 32'd1);
    chk("rst_wfull", 32'(wfull), 32'd0);
    chk("rst_waf", 32'(walmost_full), 32'd0);
    chk("rst_wlevel", 32'(wlevel), 32'd0);
    chk("rst_rlevel", 32'(rlevel), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    mon_en = 1'b1;

    // fill 16 words, then one rejected write
    for (int k = 1; k <= 16; k++) begin
      wr_cycle(1'b1, 8'(k - 1), acc);
      chk("fill_acc", 32'(acc), 32'd1);
      chk("fill_wlevel", 32'(wlevel), 32'(k));
      chk("fill_waf", 32'(walmost_full), 32'(k >= 12));
      chk("fill_wfull", 32'(wfull), 32'(k == 16));
    end
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    chk("ovf_before", 32'(woverflow), 32'd0);
`endif
    wr_cycle(1'b1, 8'hAA, acc);
    chk("full_wlevel", 32'(wlevel), 32'd16);
    chk("full_wfull", 32'(wfull), 32'd1);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    chk("woverflow", 32'(woverflow), 32'd1);
`endif

    // drain all 16
    repeat (6) @(posedge rclk);
    #1;
    chk("pre_drain_rlevel", 32'(rlevel), 32'd16);
    chk("pre_drain_rae", 32'(ralmost_empty), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      rd_cycle(1'b1, acc);
      chk("drain_acc", 32'(acc), 32'd1);
      chk("drain_rlevel", 32'(rlevel), 32'(16 - k));
      chk("drain_rae", 32'(ralmost_empty), 32'((16 - k) <= 2));
      chk("drain_rempty", 32'(rempty), 32'(k == 16));
    end
    rd_cycle(1'b1, acc);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    chk("runderflow", 32'(runderflow), 32'd1);
`endif
    repeat (8) @(posedge wclk);
    #1;
    chk("drained_wlevel", 32'(wlevel), 32'd0);
    chk("drained_wfull", 32'(wfull), 32'd0);

    // random-gap stream of 100 words across pointer wraps
    nw = 0;
    nr = 0;
    fork
      begin
        int budget = 0;
        @(posedge wclk);
        #1;
        while (nw < 100 && budget < 4000) begin
          logic a;
          wr_cycle(1'($urandom_range(0, 2) != 0), 8'($urandom), a);
          if (a) nw++;
          budget++;
        end
      end
      begin
        int budget = 0;
        @(posedge rclk);
        #1;
        while (nr < 100 && budget < 4000) begin
          logic a;
          rd_cycle(1'($urandom_range(0, 1)), a);
          if (a) nr++;
          budget++;
        end
      end
    join
    chk("wrap_writes", 32'(nw), 32'd100);
    chk("wrap_reads", 32'(nr), 32'd100);
    chk("wrap_model_empty", 32'(model_q.size()), 32'd0);
    mon_en = 1'b0;

    // write-to-empty crossing latency
    repeat (10) @(posedge rclk);
    #1;
    chk("lat_pre_rempty", 32'(rempty), 32'd1);
    @(posedge wclk);
    #1;
    chk("lat_pre_wfull", 32'(wfull), 32'd0);
    winc  = 1'b1;
    wdata = 8'h3C;
    @(posedge wclk);
    fork
      begin
        #1;
        winc = 1'b0;
      end
    join_none
    model_q.push_back(8'h3C);
    occ++;
    lat = 0;
    while (rempty && lat < 10) begin
      @(posedge rclk);
      #1;
      lat++;
    end
    chk("lat_rempty_fell", 32'(rempty), 32'd0);
    chk("lat_within_4", 32'(lat <= 4), 32'd1);
    chk("lat_rlevel", 32'(rlevel), 32'd1);
    rd_cycle(1'b1, acc);
    chk("lat_read_acc", 32'(acc), 32'd1);

    // reset with 9 words queued
    @(posedge wclk);
    #1;
    for (int i = 0; i < 9; i++) begin
      wr_cycle(1'b1, 8'(8'h80 + i), acc);
    end
    repeat (8) @(posedge rclk);
    #1;
    chk("mid_rlevel", 32'(rlevel), 32'd9);
    @(posedge wclk);
    #3;
    wrst_n = 1'b0;
    rrst_n = 1'b0;
    #1;
    chk("mid_wfull", 32'(wfull), 32'd0);
    chk("mid_waf", 32'(walmost_full), 32'd0);
    chk("mid_wlevel", 32'(wlevel), 32'd0);
    chk("mid_rempty", 32'(rempty), 32'd1);
    chk("mid_rae", 32'(ralmost_empty), 32'd1);
    chk("mid_rlevel0", 32'(rlevel), 32'd0);
    chk("mid_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rdata", 32'(rdata), 32'd0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    chk("mid_woverflow", 32'(woverflow), 32'd0);
    chk("mid_runderflow", 32'(runderflow), 32'd0);
`endif
    model_q.delete();
    occ = 0;
    repeat (3) @(posedge rclk);
    #2;
    wrst_n = 1'b1;
    rrst_n = 1'b1;
    @(posedge wclk);
    #1;
    wr_cycle(1'b1, 8'h55, acc);
    chk("post_rst_wacc", 32'(acc), 32'd1);
    repeat (6) @(posedge rclk);
    #1;
    rd_cycle(1'b1, acc);
    chk("post_rst_racc", 32'(acc), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
